// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard controller for a 5-stage RV32I pipeline: forwarding, load-use
// stall, branch/jump flush, data-memory wait-state FSM and saturating perf counters.
module hazard_unit_mc #(
  parameter int LD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_D,
  input  logic [31:0]       instr_E,
  input  logic [31:0]       instr_M,
  input  logic [31:0]       instr_W,
  input  logic              rd_wren_E,
  input  logic              rd_wren_M,
  input  logic              rd_wren_W,
  input  logic              pc_sel_E,
  input  logic              cnt_clr,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ldStall_check,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WW = (LD_LAT > 0) ? $clog2(LD_LAT + 1) : 1;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_r;
  logic [WW-1:0]     wcnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic [4:0] rs1_d_s, rs2_d_s, rs1_e_s, rs2_e_s, rd_e_s, rd_m_s, rd_w_s;
  logic [6:0] op_e_s, op_m_s;
  logic       memop_s, ldstall_s, brflush_s, mem_busy_s;
  logic       unused_s;

  // M wins over W; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wren_m, input logic [4:0] rd_w,
                                         input logic wren_w);
    logic [1:0] sel;
    if ((rs != 5'd0) && wren_m && (rs == rd_m)) begin
      sel = 2'b10;
    end else if ((rs != 5'd0) && wren_w && (rs == rd_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign rs1_d_s = instr_D[19:15];
  assign rs2_d_s = instr_D[24:20];
  assign rs1_e_s = instr_E[19:15];
  assign rs2_e_s = instr_E[24:20];
  assign rd_e_s  = instr_E[11:7];
  assign rd_m_s  = instr_M[11:7];
  assign rd_w_s  = instr_W[11:7];
  assign op_e_s  = instr_E[6:0];
  assign op_m_s  = instr_M[6:0];

  assign unused_s = ^{instr_D[31:25], instr_D[14:0], instr_E[31:25], instr_E[14:12],
                      instr_M[31:12], instr_W[31:12], instr_W[6:0]};

  assign memop_s   = (op_m_s == OP_LOAD) || (op_m_s == OP_STORE);
  assign ldstall_s = (op_e_s == OP_LOAD) && rd_wren_E && (rd_e_s != 5'd0) &&
                     ((rs1_d_s == rd_e_s) || (rs2_d_s == rd_e_s));
  assign brflush_s = pc_sel_E &&
                     ((op_e_s == OP_BRANCH) || (op_e_s == OP_JAL) || (op_e_s == OP_JALR));

  assign ForwardAE = fwd_sel(rs1_e_s, rd_m_s, rd_wren_M, rd_w_s, rd_wren_W);
  assign ForwardBE = fwd_sel(rs2_e_s, rd_m_s, rd_wren_M, rd_w_s, rd_wren_W);

  // Busy is Mealy: a memop is held from the cycle it first appears in M
  always_comb begin
    mem_busy_s = 1'b0;
    if (!rst_n || (LD_LAT == 0)) begin
      mem_busy_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    mem_busy_s = memop_s;
        WAIT:    mem_busy_s = (wcnt_r != '0);
        default: mem_busy_s = 1'b0;
      endcase
    end
  end

  // Wait-state FSM; the wcnt==0 cycle in WAIT is the release cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wcnt_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (memop_s && (LD_LAT > 0)) begin
            state_r <= WAIT;
            wcnt_r  <= WW'(LD_LAT - 1);
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (wcnt_r != '0) begin
            wcnt_r <= wcnt_r - WW'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          wcnt_r  <= '0;
        end
      endcase
    end
  end

  // Stall/flush priority: a memory wait freezes everything and hides branch/load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_busy_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldstall_s;
      StallD = ldstall_s;
      FlushD = brflush_s;
      FlushE = ldstall_s | brflush_s;
    end
  end

  assign ldStall_check = ldstall_s & ~mem_busy_s;
  assign mem_busy      = mem_busy_s;

  // Saturating performance counters, clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else if (cnt_clr) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (StallF && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (FlushD && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: three instances (LD_LAT 2/1/0) share stimulus;
// expectations are queued as each cycle is driven and compared on the falling edge.
module tb_hazard_unit_mc;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_D, instr_E, instr_M, instr_W;
  logic        rd_wren_E, rd_wren_M, rd_wren_W, pc_sel_E, cnt_clr;

  logic [2:0]  sf, sd, se, sm, fd, fe, fw, lc, mb;
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [3:0]  sc_a, fc_a;
  logic [15:0] sc_b, fc_b, sc_c, fc_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [12:0] ctl;
    int          sc;
    int          fc;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  hazard_unit_mc #(.LD_LAT(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .instr_W(instr_W), .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .pc_sel_E(pc_sel_E), .cnt_clr(cnt_clr), .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
    .StallM(sm[0]), .FlushD(fd[0]), .FlushE(fe[0]), .FlushW(fw[0]), .ForwardAE(fa[0]),
    .ForwardBE(fb[0]), .ldStall_check(lc[0]), .mem_busy(mb[0]), .stall_cnt(sc_a),
    .flush_cnt(fc_a));

  hazard_unit_mc #(.LD_LAT(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .instr_W(instr_W), .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .pc_sel_E(pc_sel_E), .cnt_clr(cnt_clr), .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
    .StallM(sm[1]), .FlushD(fd[1]), .FlushE(fe[1]), .FlushW(fw[1]), .ForwardAE(fa[1]),
    .ForwardBE(fb[1]), .ldStall_check(lc[1]), .mem_busy(mb[1]), .stall_cnt(sc_b),
    .flush_cnt(fc_b));

  hazard_unit_mc #(.LD_LAT(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .instr_E(instr_E), .instr_M(instr_M),
    .instr_W(instr_W), .rd_wren_E(rd_wren_E), .rd_wren_M(rd_wren_M), .rd_wren_W(rd_wren_W),
    .pc_sel_E(pc_sel_E), .cnt_clr(cnt_clr), .StallF(sf[2]), .StallD(sd[2]), .StallE(se[2]),
    .StallM(sm[2]), .FlushD(fd[2]), .FlushE(fe[2]), .FlushW(fw[2]), .ForwardAE(fa[2]),
    .ForwardBE(fb[2]), .ldStall_check(lc[2]), .mem_busy(mb[2]), .stall_cnt(sc_c),
    .flush_cnt(fc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [12:0] ctl(input logic [3:0] st, input logic [2:0] fl,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic ld, input logic busy);
    return {st, fl, a, b, ld, busy};
  endfunction

  function automatic logic [12:0] dut_ctl(input int k);
    return {sf[k], sd[k], se[k], sm[k], fd[k], fe[k], fw[k], fa[k], fb[k], lc[k], mb[k]};
  endfunction

  function automatic logic [31:0] dut_sc(input int k);
    return (k == 0) ? {28'd0, sc_a} : (k == 1) ? {16'd0, sc_b} : {16'd0, sc_c};
  endfunction

  function automatic logic [31:0] dut_fc(input int k);
    return (k == 0) ? {28'd0, fc_a} : (k == 1) ? {16'd0, fc_b} : {16'd0, fc_c};
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] i_jal(input logic [4:0] rd);
    return {20'd0, rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] i_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic [31:0] w, input logic we, input logic wm, input logic ww,
                       input logic ps, input logic clr);
    instr_D = d; instr_E = e; instr_M = m; instr_W = w;
    rd_wren_E = we; rd_wren_M = wm; rd_wren_W = ww;
    pc_sel_E = ps; cnt_clr = clr;
  endtask

  task automatic expect_c(input string tag, input int which, input logic [12:0] c,
                          input int sc, input int fc);
    exp_t e;
    e.tag = tag; e.which = which; e.ctl = c; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every expectation queued for this cycle against the settled outputs
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d].ctl", e.tag, e.which), {19'd0, dut_ctl(e.which)},
               {19'd0, e.ctl});
      if (e.sc >= 0) check_eq($sformatf("%s[%0d].stall_cnt", e.tag, e.which),
                              dut_sc(e.which), e.sc);
      if (e.fc >= 0) check_eq($sformatf("%s[%0d].flush_cnt", e.tag, e.which),
                              dut_fc(e.which), e.fc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [12:0] busy_c, zero_c, ldu_c, flush_c;
    busy_c  = ctl(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b1);
    zero_c  = 13'd0;
    ldu_c   = ctl(4'b1100, 3'b010, 2'b00, 2'b00, 1'b1, 1'b0);
    flush_c = ctl(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0);

    rst_n = 1'b0;
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // reset state, then combinational outputs while still in reset
    for (int k = 0; k < 3; k++) expect_c("rst", k, zero_c, 0, 0);
    tick();
    drive(i_add(5'd6, 5'd5, 5'd2), i_lw(5'd5, 5'd1), i_lw(5'd9, 5'd3), NOP,
          1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("rst_comb", 0, ldu_c, 0, 0);
    expect_c("rst_comb", 2, ldu_c, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("post_rst", 0, zero_c, 0, 0);
    tick();

    // lw reaches M with no dependent: two wait cycles, then release
    drive(NOP, NOP, i_lw(5'd5, 5'd1), NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("lw_w0", 0, busy_c, 0, -1);
    expect_c("lat0", 2, zero_c, 0, -1);
    tick();
    expect_c("lw_w1", 0, busy_c, 1, -1);
    tick();
    expect_c("lw_rel", 0, zero_c, 2, -1);
    tick();
    drive(NOP, NOP, NOP, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_c("lw_done", 0, zero_c, 2, -1);
    tick();

    // load-use: one stall cycle, then the consumer forwards from W
    drive(i_add(5'd6, 5'd5, 5'd2), i_lw(5'd5, 5'd1), NOP, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("ldu", 0, ldu_c, 2, -1);
    expect_c("ldu", 2, ldu_c, -1, -1);
    tick();
    drive(i_add(5'd6, 5'd5, 5'd2), NOP, i_lw(5'd5, 5'd1), NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("ldu_w0", 0, busy_c, 3, -1);
    tick();
    expect_c("ldu_w1", 0, busy_c, 4, -1);
    tick();
    expect_c("ldu_rel", 0, zero_c, 5, -1);
    tick();
    drive(NOP, i_add(5'd6, 5'd5, 5'd2), NOP, i_lw(5'd5, 5'd1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_c("ldu_fwdW", 0, ctl(4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0), 5, -1);
    tick();

    // taken beq held during a store wait, flushes on release
    drive(NOP, i_beq(5'd1, 5'd2), i_sw(5'd5, 5'd1), NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_c("br_w0", 0, busy_c, -1, 0);
    tick();
    expect_c("br_w1", 0, busy_c, -1, 0);
    tick();
    expect_c("br_rel", 0, flush_c, -1, 0);
    tick();
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("br_after", 0, zero_c, -1, 1);
    tick();

    // forwarding priority and qualification
    drive(NOP, i_add(5'd7, 5'd5, 5'd5), i_add(5'd5, 5'd1, 5'd2), i_add(5'd5, 5'd1, 5'd2),
          1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_c("fwd_MM", 0, ctl(4'b0000, 3'b000, 2'b10, 2'b10, 1'b0, 1'b0), -1, -1);
    expect_c("fwd_MM", 2, ctl(4'b0000, 3'b000, 2'b10, 2'b10, 1'b0, 1'b0), -1, -1);
    tick();
    drive(NOP, i_add(5'd7, 5'd1, 5'd5), i_add(5'd5, 5'd1, 5'd2), i_add(5'd5, 5'd1, 5'd2),
          1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_c("fwd_noMwren", 0, ctl(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0), -1, -1);
    tick();
    drive(NOP, i_add(5'd7, 5'd1, 5'd0), i_add(5'd0, 5'd1, 5'd2), i_add(5'd0, 5'd1, 5'd2),
          1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_c("fwd_x0", 0, zero_c, -1, -1);
    tick();
    drive(NOP, i_add(5'd7, 5'd1, 5'd5), i_add(5'd6, 5'd1, 5'd2), i_add(5'd5, 5'd1, 5'd2),
          1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_c("fwd_W", 0, ctl(4'b0000, 3'b000, 2'b00, 2'b01, 1'b0, 1'b0), -1, -1);
    tick();

    // LD_LAT=1: back-to-back loads give two 1-cycle waits split by one release
    drive(NOP, NOP, i_lw(5'd5, 5'd1), NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("b2b_w0", 1, busy_c, -1, -1);
    tick();
    expect_c("b2b_rel0", 1, zero_c, -1, -1);
    tick();
    drive(NOP, NOP, i_lw(5'd6, 5'd1), i_lw(5'd5, 5'd1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_c("b2b_w1", 1, busy_c, -1, -1);
    tick();
    expect_c("b2b_rel1", 1, zero_c, -1, -1);
    tick();
    drive(NOP, NOP, NOP, i_lw(5'd6, 5'd1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_c("b2b_done", 1, zero_c, -1, -1);
    tick();
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // jal / jalr flush; pc_sel on a non-transfer or untaken branch does nothing
    drive(NOP, i_jal(5'd1), NOP, NOP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_c("jal", 1, flush_c, -1, -1);
    expect_c("jal", 0, flush_c, -1, -1);
    tick();
    drive(NOP, i_jalr(5'd0, 5'd1), NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_c("jalr", 0, flush_c, -1, -1);
    tick();
    drive(NOP, i_add(5'd7, 5'd1, 5'd2), NOP, NOP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_c("psel_add", 0, zero_c, -1, -1);
    tick();
    drive(NOP, i_beq(5'd1, 5'd2), NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("beq_nt", 0, zero_c, -1, -1);
    tick();

    // async reset mid-WAIT, then the held load is re-detected
    drive(NOP, NOP, i_lw(5'd5, 5'd1), NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_c("rw_w0", 0, busy_c, -1, -1);
    tick();
    rst_n = 1'b0;
    expect_c("rw_rst", 0, zero_c, 0, 0);
    expect_c("rw_rst", 1, zero_c, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_c("rw_again0", 0, busy_c, 0, -1);
    tick();
    expect_c("rw_again1", 0, busy_c, 1, -1);
    tick();
    expect_c("rw_rel", 0, zero_c, 2, -1);
    tick();
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // clear during a stall cycle, then saturate the 4-bit stall counter
    drive(i_add(5'd6, 5'd5, 5'd2), i_lw(5'd5, 5'd1), NOP, NOP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_c("sat_clr", 0, ldu_c, 2, -1);
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      expect_c($sformatf("sat%0d", i), 0, ldu_c, (i < 15) ? i : 15, -1);
      tick();
    end
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_c("sat_top", 0, zero_c, 15, -1);
    tick();
    cnt_clr = 1'b1;
    expect_c("clr_cyc", 0, zero_c, 15, -1);
    tick();
    cnt_clr = 1'b0;
    expect_c("clr_after", 0, zero_c, 0, 0);
    tick();

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised multi-cycle hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W). It replaces the single-cycle hazard logic with a version that adds:
- a data-memory wait-state FSM (`LD_LAT` extra cycles for loads and stores in M);
- load-use stall qualified by write-enable and a non-zero destination;
- taken-branch/jump flush covering JAL and JALR;
- saturating stall and flush performance counters.

It sits beside the pipeline registers and drives their stall, flush and forward selects.

## Interface
- `LD_LAT`, default 2: data-memory wait cycles per load/store in M; 0 disables the FSM.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_D`, `instr_E`, `instr_M`, `instr_W` in 32: instruction word in each stage.
- `rd_wren_E`, `rd_wren_M`, `rd_wren_W` in 1: stage writes `rd`.
- `pc_sel_E` in 1: control transfer in E is taken.
- `cnt_clr` in 1: synchronous clear of both counters.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the stage register.
- `FlushD`, `FlushE`, `FlushW` out 1: bubble the stage register.
- `ForwardAE`, `ForwardBE` out 2: operand select. 00 = register file, 10 = M, 01 = W.
- `ldStall_check` out 1: load-use stall active (debug).
- `mem_busy` out 1: FSM stall active (debug).
- `stall_cnt` out `CNT_W`: cycles with `StallF`=1.
- `flush_cnt` out `CNT_W`: cycles with `FlushD`=1.

## Operation
Decoded fields:
- `rs1` = [19:15], `rs2` = [24:20], `rd` = [11:7].
- `memop_M`: `instr_M[6:0]` is 0000011 (load) or 0100011 (store).

Forwarding (combinational, per operand independently):
- M has priority if `rs_E == rd_M`, `rd_wren_M`=1 and `rs_E != 0`.
- Otherwise W under the same rule.
- Otherwise 00.

Load-use stall:
- `ldStall` = `instr_E[6:0]`==0000011 & `rd_wren_E` & `rd_E != 0` & (`rs1_D == rd_E` | `rs2_D == rd_E`).

Branch flush:
- `brFlush` = `pc_sel_E` & opcode_E ∈ {1100011, 1101111, 1100111}.

FSM, states IDLE and WAIT, with a down-counter `wcnt` of width clog2(`LD_LAT`+1):
- IDLE & `memop_M` & `LD_LAT`>0: `mem_busy`=1, load `wcnt`=`LD_LAT`-1, go to WAIT.
- IDLE otherwise: `mem_busy`=0.
- WAIT & `wcnt`!=0: `mem_busy`=1, decrement `wcnt`.
- WAIT & `wcnt`==0: `mem_busy`=0, go to IDLE. The memory op advances out of M this cycle.
- A back-to-back memop that enters M on the release edge is detected in IDLE on the next cycle and starts a new wait.

Output priority:
- While `mem_busy`=1:
  - `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1.
  - `FlushD` = `FlushE` = 0.
  - `ldStall` and `brFlush` are suppressed in the outputs, because the branch in E is held and redirects after release.
- Otherwise:
  - `StallF` = `StallD` = `ldStall`.
  - `FlushD` = `brFlush`.
  - `FlushE` = `ldStall` | `brFlush`.
  - `StallE` = `StallM` = `FlushW` = 0.
- `ldStall_check` shows the suppressed (gated) value.

Counters:
- Each saturates at all-ones.
- `cnt_clr` takes priority over increment.

## Timing
- Reset: FSM = IDLE, `wcnt` = 0, `stall_cnt` = 0, `flush_cnt` = 0, hence `mem_busy` = 0.
- During and after reset, all stall, flush and forward outputs are the pure combinational functions above with `mem_busy`=0.
- Reset asserted mid-WAIT returns the FSM to IDLE immediately (asynchronous). The held memop is re-detected in IDLE after release.
- Memory-op stall length is exactly `LD_LAT` cycles. The instruction occupies M for `LD_LAT`+1 cycles.
- `LD_LAT`=0: `mem_busy` is never asserted. Behaviour matches the single-cycle hazard unit plus the `rd`/wren qualification and JAL/JALR flush.
- Load-use stall is one cycle: the load moves to M while the consumer is held in D and E is bubbled. The load then forwards from W.
- Counters update on the rising `clk` edge following the counted cycle. A `cnt_clr` cycle reads 0 next cycle, even if that cycle was itself a stall.

## Test plan
1. `LD_LAT`=2, `lw x5` reaches M with no dependent: `mem_busy`=1 for 2 cycles, `StallF..M`=1 and `FlushW`=1 for those cycles. The lw then leaves M, and `stall_cnt` reads 2.
2. `lw x5,0(x1)` in E with `add x6,x5,x2` in D: `ldStall_check`=1, `StallF`=`StallD`=`FlushE`=1 for 1 cycle (memop wait excluded). The next E cycle shows `ForwardAE`=01.
3. `beq` taken in E (`pc_sel_E`=1) while `mem_busy`=1: `FlushD`=`FlushE`=0 during the wait. On the release cycle `FlushD`=`FlushE`=1 and `flush_cnt` increments by 1.
4. x5 written in both M and W and read as rs2 in E: `ForwardBE`=10. Same setup with rs2=x0 or `rd_wren_M`=0 → 00 or 01 respectively.
5. Two back-to-back loads (`LD_LAT`=1): two separate 1-cycle waits separated by exactly one release cycle. `jal` with `pc_sel_E`=1 → `FlushD`=1.
6. `rst_n` dropped during WAIT: `mem_busy`=0 immediately and counters are 0. With `CNT_W`=4 and 20 forced stall cycles, `stall_cnt` saturates at 15. `cnt_clr`=1 → 0 next cycle.
